// File: rtl/pc_pkg.sv
// Shared types and reset/exception vectors for the fetch-stage PC controller.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Encoding is ordered so that a numeric compare gives redirect priority.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        JMP  = 2'd1,
        BR   = 2'd2,
        EXC  = 2'd3
    } redir_src_t;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority select among exception, branch and jump redirects, and the check
// that decides whether a new redirect may overwrite the pending one.
module pc_redirect_arb import pc_pkg::*; #(
    parameter int                   ADR_WIDTH  = 32,
    parameter logic [ADR_WIDTH-1:0] EXC_VEC    = ADR_WIDTH'(pc_pkg::EXC_VEC),
    parameter int                   INST_BYTES = 4
) (
    input  logic                 exc_valid,
    input  logic                 br_valid,
    input  logic [ADR_WIDTH-1:0] br_target,
    input  logic                 jmp_valid,
    input  logic [ADR_WIDTH-1:0] jmp_target,
    input  redir_src_t           pend_src,
    output redir_src_t           redir_src,
    output logic [ADR_WIDTH-1:0] redir_target,
    output logic                 redir_replace
);

    localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ~(ADR_WIDTH'(INST_BYTES - 1));

    logic [ADR_WIDTH-1:0] raw_target;

    always_comb begin
        redir_src  = NONE;
        raw_target = '0;
        if (exc_valid) begin
            redir_src  = EXC;
            raw_target = EXC_VEC;
        end else if (br_valid) begin
            redir_src  = BR;
            raw_target = br_target;
        end else if (jmp_valid) begin
            redir_src  = JMP;
            raw_target = jmp_target;
        end
    end

    assign redir_target  = raw_target & ALIGN_MASK;
    assign redir_replace = (redir_src != NONE) && (redir_src >= pend_src);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: next-PC selection, imem req/ack handshake,
// stall hold of the acked instruction and IF/ID, ID/EX flush pulses.
//
//   state | meaning
//   IDLE  | one cycle after reset, next request goes to RESET_VEC
//   REQ   | imem_req high, imem_addr stable until ack
//   HOLD  | instruction acked under stall, offered until stall drops
module pc_fetch_ctrl import pc_pkg::*; #(
    parameter int                   ADR_WIDTH  = 32,
    parameter logic [ADR_WIDTH-1:0] RESET_VEC  = ADR_WIDTH'(pc_pkg::RESET_VEC),
    parameter logic [ADR_WIDTH-1:0] EXC_VEC    = ADR_WIDTH'(pc_pkg::EXC_VEC),
    parameter int                   INST_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 br_valid,
    input  logic [ADR_WIDTH-1:0] br_target,
    input  logic                 jmp_valid,
    input  logic [ADR_WIDTH-1:0] jmp_target,
    input  logic                 exc_valid,
    output logic                 imem_req,
    output logic [ADR_WIDTH-1:0] imem_addr,
    input  logic                 imem_ack,
    output logic [ADR_WIDTH-1:0] o_pc,
    output logic                 o_inst_valid,
    output logic                 flush_if,
    output logic                 flush_id
);

    localparam logic [ADR_WIDTH-1:0] STEP       = ADR_WIDTH'(INST_BYTES);
    localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ~(ADR_WIDTH'(INST_BYTES - 1));
    localparam logic [ADR_WIDTH-1:0] RESET_ADDR = RESET_VEC & ALIGN_MASK;

    fetch_state_t         state_q, state_d;
    logic [ADR_WIDTH-1:0] addr_q, addr_d;
    logic [ADR_WIDTH-1:0] pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic                 flush_if_q, flush_if_d;
    logic                 flush_id_q, flush_id_d;
    redir_src_t           pend_src_q, pend_src_d;
    logic [ADR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    redir_src_t           redir_src;
    logic [ADR_WIDTH-1:0] redir_target;
    logic                 redir_replace;

    pc_redirect_arb #(
        .ADR_WIDTH  (ADR_WIDTH),
        .EXC_VEC    (EXC_VEC),
        .INST_BYTES (INST_BYTES)
    ) u_arb (
        .exc_valid     (exc_valid),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .jmp_valid     (jmp_valid),
        .jmp_target    (jmp_target),
        .pend_src      (pend_src_q),
        .redir_src     (redir_src),
        .redir_target  (redir_target),
        .redir_replace (redir_replace)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= RESET_ADDR;
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            flush_if_q <= 1'b0;
            flush_id_q <= 1'b0;
            pend_src_q <= NONE;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            flush_if_q <= flush_if_d;
            flush_id_q <= flush_id_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        flush_if_d = 1'b0;
        flush_id_d = 1'b0;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;

        if (redir_replace) begin
            flush_if_d = 1'b1;
            flush_id_d = (redir_src == EXC) || (redir_src == BR);
            valid_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                addr_d  = redir_replace ? redir_target : RESET_ADDR;
            end
            REQ: begin
                valid_d = 1'b0;
                // The in-flight request is never aborted; redirects wait here.
                if (redir_replace) begin
                    pend_src_d = redir_src;
                    pend_tgt_d = redir_target;
                end
                if (imem_ack) begin
                    if (pend_src_d != NONE) begin
                        addr_d     = pend_tgt_d;
                        pend_src_d = NONE;
                    end else begin
                        pc_d    = addr_q;
                        valid_d = 1'b1;
                        if (stall) state_d = HOLD;
                        else       addr_d  = addr_q + STEP;
                    end
                end
            end
            HOLD: begin
                if (redir_replace) begin
                    state_d = REQ;
                    addr_d  = redir_target;
                end else if (!stall) begin
                    state_d = REQ;
                    addr_d  = pc_q + STEP;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = addr_q;
    assign o_pc         = pc_q;
    assign o_inst_valid = valid_q;
    assign flush_if     = flush_if_q;
    assign flush_id     = flush_id_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the fetch-stage program counter for the MIPS pipeline.
- Arbitrates among next-PC sources: sequential, ID-stage jump, EX-stage branch and exception vector.
- Runs the req/ack handshake with instruction memory, honours hazard-unit stalls, and emits IF/ID flush pulses.
- Sits between the hazard/branch logic and the IF/ID pipeline register.

Parameters:
ADR_WIDTH, 32, address width (matches `ADR_WIDTH)
RESET_VEC, 32'h0000_0000, first fetch address after reset
EXC_VEC, 32'h0000_0080, exception handler address
INST_BYTES, 4, PC increment; low log2(INST_BYTES) bits of every target are forced to 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard unit: IF/ID must not advance
br_valid  in  1  EX-stage taken branch
br_target  in  ADR_WIDTH  branch target
jmp_valid  in  1  ID-stage jump
jmp_target  in  ADR_WIDTH  jump target
exc_valid  in  1  exception request
imem_req  out  1  fetch request
imem_addr  out  ADR_WIDTH  fetch address
imem_ack  in  1  fetch complete; instruction valid on the memory side this cycle
o_pc  out  ADR_WIDTH  PC of the instruction offered to IF/ID
o_inst_valid  out  1  instruction offered to IF/ID; IF/ID captures on o_inst_valid && !stall
flush_if  out  1  one-cycle pulse: kill IF/ID contents
flush_id  out  1  one-cycle pulse: kill ID/EX contents

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, imem_req=0, imem_addr=RESET_VEC, o_pc=RESET_VEC.
  - o_inst_valid=0, flush_if=0, flush_id=0, pending redirect cleared.
- States:
  - IDLE: go to REQ next cycle with imem_addr=RESET_VEC.
  - REQ: imem_req=1. imem_addr is stable until the edge where imem_ack=1.
    - Ack may arrive in the first REQ cycle (zero-wait memory).
  - HOLD: the instruction was acked while stall=1. o_inst_valid stays 1, o_pc stays fixed, imem_req=0.
- On ack in REQ with no redirect that cycle and no pending redirect:
  - o_pc<=imem_addr and o_inst_valid<=1 next cycle.
  - If stall=0 at that edge: state stays REQ, imem_addr<=imem_addr+INST_BYTES.
  - If stall=1: state<=HOLD.
- HOLD exit: at the edge where stall=0, the instruction is consumed. Next cycle: state=REQ, imem_addr=o_pc+INST_BYTES, o_inst_valid=0 unless a new ack follows.
- Redirect priority when asserted in the same cycle: exc > br > jmp. Resulting target is EXC_VEC, br_target or jmp_target.
- Any accepted redirect:
  - flush_if pulses 1 the next cycle.
  - flush_id also pulses for exc or br, not for jmp.
  - o_inst_valid<=0.
- Redirect while in REQ without ack, or coincident with ack:
  - The in-flight request is not aborted.
  - Target is latched in a pending register together with a 2-bit source tag.
  - The acked instruction is discarded (o_inst_valid stays 0).
  - The next request uses the pending target; pending is cleared when that request is issued.
- Redirect while a pending redirect exists: the new one replaces pending only if its priority is >= the pending priority.
- Redirect in HOLD or IDLE: the held instruction is dropped and state<=REQ with imem_addr=target next cycle.
- stall does not block redirects.
- Arithmetic: the PC increment wraps modulo 2^ADR_WIDTH (e.g. 32'hFFFF_FFFC -> 32'h0).
- Reset asserted mid-request returns to IDLE immediately. A late imem_ack is ignored while in IDLE.

Decomposition:
- Package pc_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD}.
  - redir_src_t enum {NONE, JMP, BR, EXC} with ordered encoding so priority compare is numeric.
  - Constants RESET_VEC and EXC_VEC.
- One sub-module, pc_redirect_arb: combinational priority select of target and source, plus pending-replace compare.
- The FSM, pending register and PC registers stay in pc_fetch_ctrl.

Test Plan:
- Reset release, imem_ack tied high: imem_addr sequence 0x0, 0x4, 0x8. o_pc follows one cycle behind. o_inst_valid=1 from the 2nd REQ cycle.
- Ack with a 2-cycle wait, stall=1 for 3 cycles at ack: state HOLD, o_pc=0x4 held, imem_req=0. After stall drops, the next request is to 0x8.
- br_valid=1 with br_target=0x100, jmp_valid=1 with jmp_target=0x200 in the same cycle: next imem_addr=0x100. flush_if=1 and flush_id=1 for exactly one cycle.
- jmp_target=0x40 while a request to 0x10 is waiting for ack, then exc_valid=1 one cycle later:
  - 0x10 completes and is discarded (o_inst_valid=0).
  - Next imem_addr=0x80.
  - flush_id=1 on the exception, not on the jump.
- Sequential fetch from imem_addr=0xFFFF_FFFC: next imem_addr=0x0. A target of 0x103 is issued as 0x100.
- rst=0 asserted asynchronously mid-REQ with imem_ack=1 shortly after: outputs reach reset values without a clock edge. The ack is ignored and fetch restarts at RESET_VEC after release.
